// File: rtl/mtm_alu_deserializer.sv
// Serial receive front-end of mtm_Alu: collects 8 data frames plus 1 command frame from sin,
// validates framing, byte count, CRC-4 and opcode, then emits one operand set or one error report.
module mtm_alu_deserializer #(
  parameter int IDLE_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sin,
  output logic [31:0] b_out,
  output logic [31:0] a_out,
  output logic [2:0]  op_out,
  output logic        data_valid,
  output logic [2:0]  err_out,
  output logic        err_valid
);

  localparam int TW = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [TW-1:0] IDLE_LIM = TW'(IDLE_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TYPE,
    S_PAYLOAD,
    S_STOP,
    S_REPORT
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic          r_type;
  logic [7:0]    r_shift;
  logic [2:0]    r_bit_cnt;
  logic [63:0]   r_ba;
  logic [3:0]    r_count;
  logic [TW-1:0] r_idle_cnt;
  logic [31:0]   r_b;
  logic [31:0]   r_a;
  logic [2:0]    r_op;
  logic [2:0]    r_err;
  logic          r_dv;
  logic          r_ev;
  logic [3:0]    w_crc;
  logic          w_crc_ok;
  logic          w_op_ok;

  // Serial CRC-4 (x^4+x+1, init 0) unrolled so it settles within the STOP cycle.
  function automatic logic [3:0] crc4_calc(input logic [67:0] d);
    logic [3:0] c;
    c = 4'b0000;
    for (int i = 67; i >= 0; i--) begin
      c = {c[2:0], 1'b0} ^ ({4{c[3] ^ d[i]}} & 4'b0011);
    end
    return c;
  endfunction

  assign w_crc    = crc4_calc({r_ba, 1'b1, r_shift[6:4]});
  assign w_crc_ok = (w_crc == r_shift[3:0]);
  // Legal opcodes 000,001,100,101 are exactly those with OP[1]==0.
  assign w_op_ok  = ~r_shift[5];

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (!sin) w_next = S_TYPE;
      S_TYPE:    w_next = S_PAYLOAD;
      S_PAYLOAD: if (r_bit_cnt == 3'd0) w_next = S_STOP;
      S_STOP:    w_next = (!sin || r_type) ? S_REPORT : S_IDLE;
      S_REPORT:  w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_type     <= 1'b0;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_ba       <= '0;
      r_count    <= '0;
      r_idle_cnt <= '0;
      r_b        <= '0;
      r_a        <= '0;
      r_op       <= '0;
      r_err      <= '0;
      r_dv       <= 1'b0;
      r_ev       <= 1'b0;
    end else begin
      r_dv <= 1'b0;
      r_ev <= 1'b0;
      case (r_state)
        S_TYPE: begin
          r_type    <= sin;
          r_bit_cnt <= 3'd7;
        end
        S_PAYLOAD: begin
          r_shift   <= {r_shift[6:0], sin};
          r_bit_cnt <= r_bit_cnt - 3'd1;
        end
        S_STOP: begin
          if (!sin) begin
            r_ev    <= 1'b1;
            r_err   <= 3'b100;
            r_count <= '0;
          end else if (!r_type) begin
            r_ba <= {r_ba[55:0], r_shift};
            if (r_count != 4'd9) r_count <= r_count + 4'd1;
          end else begin
            r_count <= '0;
            r_b     <= r_ba[63:32];
            r_a     <= r_ba[31:0];
            r_op    <= r_shift[6:4];
            if (r_count != 4'd8) begin
              r_ev  <= 1'b1;
              r_err <= 3'b100;
            end else if (!w_crc_ok) begin
              r_ev  <= 1'b1;
              r_err <= 3'b010;
            end else if (!w_op_ok) begin
              r_ev  <= 1'b1;
              r_err <= 3'b001;
            end else begin
              r_dv  <= 1'b1;
              r_err <= 3'b000;
            end
          end
        end
        default: ;
      endcase
      // A stalled partial message is dropped after IDLE_TIMEOUT idle-high clocks.
      if (r_state == S_IDLE && sin && r_count != 4'd0) begin
        if (r_idle_cnt == IDLE_LIM) begin
          r_idle_cnt <= '0;
          r_count    <= '0;
        end else begin
          r_idle_cnt <= r_idle_cnt + 1'b1;
        end
      end else begin
        r_idle_cnt <= '0;
      end
    end
  end

  assign b_out      = r_b;
  assign a_out      = r_a;
  assign op_out     = r_op;
  assign data_valid = r_dv;
  assign err_out    = r_err;
  assign err_valid  = r_ev;

endmodule

// File: tb/tb_mtm_alu_deserializer.sv
// Directed bench for mtm_alu_deserializer: frames are driven bit by bit on sin and the
// report pulse is checked on the clock right after the command stop bit.
module tb_mtm_alu_deserializer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sin = 1'b1;
  logic [31:0] b_out;
  logic [31:0] a_out;
  logic [2:0]  op_out;
  logic        data_valid;
  logic [2:0]  err_out;
  logic        err_valid;

  int n_tests = 0;
  int n_fail  = 0;
  int dv_cnt  = 0;
  int ev_cnt  = 0;
  bit both_seen = 1'b0;

  mtm_alu_deserializer #(.IDLE_TIMEOUT(64)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sin        (sin),
    .b_out      (b_out),
    .a_out      (a_out),
    .op_out     (op_out),
    .data_valid (data_valid),
    .err_out    (err_out),
    .err_valid  (err_valid)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (data_valid === 1'b1) dv_cnt++;
    if (err_valid === 1'b1) ev_cnt++;
    if (data_valid === 1'b1 && err_valid === 1'b1) both_seen = 1'b1;
  end

  // Reference CRC by polynomial long division of {B,A,1,OP} * x^4 by 10011.
  function automatic logic [3:0] crc_model(input logic [31:0] b, input logic [31:0] a,
                                           input logic [2:0] op);
    logic [71:0] r;
    r = {b, a, 1'b1, op, 4'b0000};
    for (int i = 71; i >= 4; i--) begin
      if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
    end
    return r[3:0];
  endfunction

  task automatic send_bit(input logic b);
    sin = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_idle(input int n);
    repeat (n) send_bit(1'b1);
  endtask

  task automatic send_frame(input logic typ, input logic [7:0] pl, input logic stop);
    send_bit(1'b0);
    send_bit(typ);
    for (int i = 7; i >= 0; i--) send_bit(pl[i]);
    send_bit(stop);
  endtask

  task automatic send_data(input logic [63:0] ba, input int n);
    for (int i = 0; i < n; i++) send_frame(1'b0, ba[63-8*i -: 8], 1'b1);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    sin   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({b_out, a_out, op_out, data_valid, err_out, err_valid} !== 72'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got b=%h a=%h op=%b dv=%b err=%b ev=%b, want all 0",
               b_out, a_out, op_out, data_valid, err_out, err_valid);
    end
    rst_n = 1'b1;
    send_idle(2);
  endtask

  task automatic test_good_zero;
    int d0;
    d0 = dv_cnt;
    send_data(64'd0, 8);
    send_frame(1'b1, {1'b0, 3'b000, 4'b1011}, 1'b1);
    n_tests++;
    if (data_valid !== 1'b1 || err_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_pulse: got dv=%b ev=%b, want dv=1 ev=0", data_valid, err_valid);
    end
    n_tests++;
    if (b_out !== 32'd0 || a_out !== 32'd0 || op_out !== 3'b000) begin
      n_fail++;
      $display("FAIL zero_operands: got b=%h a=%h op=%b, want 0 0 000", b_out, a_out, op_out);
    end
    send_bit(1'b1);
    n_tests++;
    if (data_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_pulse_width: got dv=%b one clk later, want 0", data_valid);
    end
    send_idle(1);
    n_tests++;
    if (dv_cnt - d0 != 1) begin
      n_fail++;
      $display("FAIL zero_pulse_count: got %0d data_valid cycles, want 1", dv_cnt - d0);
    end
  endtask

  task automatic test_bad_crc;
    int d0;
    d0 = dv_cnt;
    send_data(64'd0, 8);
    send_frame(1'b1, {1'b0, 3'b000, 4'b1010}, 1'b1);
    n_tests++;
    if (err_valid !== 1'b1 || err_out !== 3'b010 || data_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bad_crc: got ev=%b err=%b dv=%b, want ev=1 err=010 dv=0",
               err_valid, err_out, data_valid);
    end
    send_idle(2);
    n_tests++;
    if (dv_cnt != d0) begin
      n_fail++;
      $display("FAIL bad_crc_no_dv: got %0d data_valid cycles, want 0", dv_cnt - d0);
    end
  endtask

  task automatic test_bad_op;
    logic [3:0] c;
    c = crc_model(32'd1, 32'd2, 3'b010);
    send_data({32'd1, 32'd2}, 8);
    send_frame(1'b1, {1'b0, 3'b010, c}, 1'b1);
    n_tests++;
    if (err_valid !== 1'b1 || err_out !== 3'b001 || data_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bad_op: got ev=%b err=%b dv=%b, want ev=1 err=001 dv=0",
               err_valid, err_out, data_valid);
    end
    send_idle(2);
  endtask

  task automatic test_good_operands;
    logic [3:0] c;
    c = crc_model(32'hDEADBEEF, 32'h12345678, 3'b101);
    send_data({32'hDEADBEEF, 32'h12345678}, 8);
    send_frame(1'b1, {1'b1, 3'b101, c}, 1'b1);
    n_tests++;
    if (data_valid !== 1'b1 || err_valid !== 1'b0 || b_out !== 32'hDEADBEEF ||
        a_out !== 32'h12345678 || op_out !== 3'b101) begin
      n_fail++;
      $display("FAIL good_operands: got dv=%b ev=%b b=%h a=%h op=%b, want 1 0 deadbeef 12345678 101",
               data_valid, err_valid, b_out, a_out, op_out);
    end
    send_idle(2);
  endtask

  task automatic test_count;
    logic [3:0] c;
    c = crc_model(32'h01020304, 32'h05060708, 3'b000);
    send_data({32'h01020304, 32'h05060708}, 7);
    send_frame(1'b1, {1'b0, 3'b000, c}, 1'b1);
    n_tests++;
    if (err_valid !== 1'b1 || err_out !== 3'b100 || data_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL count_7: got ev=%b err=%b dv=%b, want ev=1 err=100 dv=0",
               err_valid, err_out, data_valid);
    end
    send_idle(2);
    send_frame(1'b0, 8'h5A, 1'b1);
    send_data({32'h01020304, 32'h05060708}, 8);
    send_frame(1'b1, {1'b0, 3'b000, c}, 1'b1);
    n_tests++;
    if (err_valid !== 1'b1 || err_out !== 3'b100 || data_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL count_9: got ev=%b err=%b dv=%b, want ev=1 err=100 dv=0",
               err_valid, err_out, data_valid);
    end
    send_idle(2);
  endtask

  task automatic test_stop_error;
    logic [3:0] c;
    send_data(64'hA1A2A3A4A5A6A7A8, 2);
    send_frame(1'b0, 8'hA5, 1'b0);
    n_tests++;
    if (err_valid !== 1'b1 || err_out !== 3'b100 || data_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stop_bit: got ev=%b err=%b dv=%b, want ev=1 err=100 dv=0",
               err_valid, err_out, data_valid);
    end
    send_idle(2);
    c = crc_model(32'h11223344, 32'h55667788, 3'b001);
    send_data({32'h11223344, 32'h55667788}, 8);
    send_frame(1'b1, {1'b0, 3'b001, c}, 1'b1);
    n_tests++;
    if (data_valid !== 1'b1 || err_valid !== 1'b0 || b_out !== 32'h11223344 ||
        a_out !== 32'h55667788 || op_out !== 3'b001) begin
      n_fail++;
      $display("FAIL stop_recover: got dv=%b ev=%b b=%h a=%h op=%b, want 1 0 11223344 55667788 001",
               data_valid, err_valid, b_out, a_out, op_out);
    end
    send_idle(2);
  endtask

  task automatic test_reset_midframe;
    int d0;
    int e0;
    logic [3:0] c;
    send_data(64'hFFEEDDCCBBAA9988, 4);
    d0 = dv_cnt;
    e0 = ev_cnt;
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    rst_n = 1'b0;
    sin   = 1'b0;
    @(posedge clk);
    #1;
    n_tests++;
    if (data_valid !== 1'b0 || err_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_pulses: got dv=%b ev=%b, want 0 0", data_valid, err_valid);
    end
    rst_n = 1'b1;
    send_idle(2);
    c = crc_model(32'hCAFEF00D, 32'h0BADBEEF, 3'b100);
    send_data({32'hCAFEF00D, 32'h0BADBEEF}, 8);
    send_frame(1'b1, {1'b0, 3'b100, c}, 1'b1);
    n_tests++;
    if (data_valid !== 1'b1 || b_out !== 32'hCAFEF00D || a_out !== 32'h0BADBEEF ||
        op_out !== 3'b100) begin
      n_fail++;
      $display("FAIL midreset_msg: got dv=%b b=%h a=%h op=%b, want 1 cafef00d 0badbeef 100",
               data_valid, b_out, a_out, op_out);
    end
    send_idle(2);
    n_tests++;
    if (dv_cnt - d0 != 1 || ev_cnt != e0) begin
      n_fail++;
      $display("FAIL midreset_counts: got dv=%0d ev=%0d, want dv=1 ev=0", dv_cnt - d0, ev_cnt - e0);
    end
  endtask

  task automatic test_timeout;
    int d0;
    int e0;
    logic [3:0] c;
    d0 = dv_cnt;
    e0 = ev_cnt;
    send_data(64'h0102030405060708, 4);
    send_idle(64);
    c = crc_model(32'h89ABCDEF, 32'h76543210, 3'b000);
    send_data({32'h89ABCDEF, 32'h76543210}, 8);
    send_frame(1'b1, {1'b0, 3'b000, c}, 1'b1);
    n_tests++;
    if (data_valid !== 1'b1 || err_valid !== 1'b0 || b_out !== 32'h89ABCDEF ||
        a_out !== 32'h76543210) begin
      n_fail++;
      $display("FAIL timeout_msg: got dv=%b ev=%b b=%h a=%h, want 1 0 89abcdef 76543210",
               data_valid, err_valid, b_out, a_out);
    end
    send_idle(2);
    n_tests++;
    if (dv_cnt - d0 != 1 || ev_cnt != e0) begin
      n_fail++;
      $display("FAIL timeout_counts: got dv=%0d ev=%0d, want dv=1 ev=0", dv_cnt - d0, ev_cnt - e0);
    end
  endtask

  task automatic test_exclusive;
    n_tests++;
    if (both_seen !== 1'b0) begin
      n_fail++;
      $display("FAIL exclusive_pulses: got dv and ev high together, want never");
    end
  endtask

  initial begin
    test_reset();
    test_good_zero();
    test_bad_crc();
    test_bad_op();
    test_good_operands();
    test_count();
    test_stop_error();
    test_reset_midframe();
    test_timeout();
    test_exclusive();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
